// File: rtl/spq_if.sv
// Producer/consumer bundle for spq_sorted_queue: the master drives enqueue/dequeue
// and data, and the slave returns the head entry and status flags.
interface spq_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic              enqueue_sig;
    logic              dequeue_sig;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              empty;
    logic              full;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;

    modport master (
        output enqueue_sig, dequeue_sig, data_in,
        input  data_out, empty, full, count, overflow, underflow
    );

    modport slave (
        input  enqueue_sig, dequeue_sig, data_in,
        output data_out, empty, full, count, overflow, underflow
    );
endinterface

// File: rtl/spq_sorted_queue.sv
// Clocked systolic sorted priority queue. slot[0] is the head; each slot picks its next value
// from its neighbours and data_in. Optional macro SPQ_EVICT_EN: a full-queue enqueue evicts the tail.
module spq_sorted_queue #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int MAX_FIRST = 1
) (
    input logic  clk,
    input logic  rst_n,
    spq_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_EVICT,
        OP_POP,
        OP_SWAP
    } op_e;

    logic [DATA_W-1:0] slot_q [DEPTH];
    logic [DATA_W-1:0] slot_d [DEPTH];
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    // ext[i+1] mirrors slot[i]; ext[0] and ext[DEPTH+1] are zero boundaries.
    logic [DATA_W-1:0] ext [DEPTH+2];
    // kx[i+1]: slot[i] is valid and stays ahead of data_in (ties stay ahead).
    logic [DEPTH+1:0]  kx;
    logic              is_empty, is_full;
    logic              ovf_set, udf_set;
    op_e               op;

    function automatic logic outranks(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (MAX_FIRST != 0) ? (a > b) : (a < b);
    endfunction

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));

    always_comb begin
        for (int unsigned i = 0; i < DEPTH + 2; i++) begin
            ext[i] = '0;
        end
        kx    = '0;
        kx[0] = 1'b1;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ext[i+1] = slot_q[i];
            kx[i+1]  = (CW'(i) < count_q) && !outranks(bus.data_in, slot_q[i]);
        end
    end

    always_comb begin
        op      = OP_IDLE;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (bus.enqueue_sig && bus.dequeue_sig) begin
            if (is_empty) begin
                op      = OP_PUSH;
                udf_set = 1'b1;
            end else begin
                op = OP_SWAP;
            end
        end else if (bus.enqueue_sig) begin
            if (!is_full) begin
                op = OP_PUSH;
            end else begin
`ifdef SPQ_EVICT_EN
                if (outranks(bus.data_in, slot_q[DEPTH-1])) begin
                    op = OP_EVICT;
                end else begin
                    ovf_set = 1'b1;
                end
`else
                ovf_set = 1'b1;
`endif
            end
        end else if (bus.dequeue_sig) begin
            if (is_empty) begin
                udf_set = 1'b1;
            end else begin
                op = OP_POP;
            end
        end
    end

    // Swap treats slot[1..] as the surviving list, so every index shifts by one relative to push.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot_d[i] = slot_q[i];
            unique case (op)
                OP_PUSH, OP_EVICT: slot_d[i] = kx[i+1] ? ext[i+1] : (kx[i] ? bus.data_in : ext[i]);
                OP_POP:            slot_d[i] = ext[i+2];
                OP_SWAP:           slot_d[i] = kx[i+2] ? ext[i+2]
                                             : (((i == 0) || kx[i+1]) ? bus.data_in : ext[i+1]);
                default:           slot_d[i] = slot_q[i];
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        unique case (op)
            OP_PUSH: count_d = count_q + CW'(1);
            OP_POP:  count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q | ovf_set;
        udf_d = udf_q | udf_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign bus.data_out  = slot_q[0];
    assign bus.count     = count_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;
endmodule

// File: tb/tb_spq_sorted_queue.sv
// Self-checking bench for spq_sorted_queue: directed tables, corner sequences and a
// randomized run against a queue-based reference model.
module tb_spq_sorted_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spq_if #(.DATA_W(8), .DEPTH(8)) ia ();
    spq_if #(.DATA_W(16), .DEPTH(8)) ib ();

    spq_sorted_queue #(.DATA_W(8), .DEPTH(8), .MAX_FIRST(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia)
    );
    spq_sorted_queue #(.DATA_W(16), .DEPTH(8), .MAX_FIRST(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib)
    );

    int checks = 0;
    int failures = 0;

    // Reference model for the max-first 8-bit queue.
    int unsigned mq[$];
    bit m_ovf, m_udf;

    typedef struct {
        int unsigned val;
        int unsigned tag;
    } ent_t;
    ent_t sb[$];
    int unsigned next_tag;

    typedef struct {
        bit          enq;
        bit          deq;
        int unsigned din;
        int unsigned exp_out;
        int unsigned exp_cnt;
        bit          exp_empty;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic m_insert(input int unsigned v);
        int k = 0;
        while (k < mq.size() && !(v > mq[k])) k++;
        mq.insert(k, v);
    endtask

    task automatic m_step(input bit e, input bit d, input int unsigned v);
        if (e && d && mq.size() > 0) begin
            void'(mq.pop_front());
            m_insert(v);
        end else begin
            if (d) begin
                if (mq.size() == 0) m_udf = 1'b1;
                else void'(mq.pop_front());
            end
            if (e) begin
                if (mq.size() < 8) m_insert(v);
                else begin
`ifdef SPQ_EVICT_EN
                    if (v > mq[7]) begin
                        void'(mq.pop_back());
                        m_insert(v);
                    end else m_ovf = 1'b1;
`else
                    m_ovf = 1'b1;
`endif
                end
            end
        end
    endtask

    task automatic step_a(input bit e, input bit d, input int unsigned v);
        ia.enqueue_sig = e;
        ia.dequeue_sig = d;
        ia.data_in     = 8'(v);
        @(posedge clk);
        #1;
        ia.enqueue_sig = 1'b0;
        ia.dequeue_sig = 1'b0;
        m_step(e, d, v);
        chk("a_data_out", ia.data_out, (mq.size() > 0) ? mq[0] : 0);
        chk("a_count", ia.count, mq.size());
        chk("a_empty", ia.empty, mq.size() == 0);
        chk("a_full", ia.full, mq.size() == 8);
        chk("a_overflow", ia.overflow, m_ovf);
        chk("a_underflow", ia.underflow, m_udf);
    endtask

    task automatic step_b(input bit e, input bit d, input int unsigned v);
        int k;
        ib.enqueue_sig = e;
        ib.dequeue_sig = d;
        ib.data_in     = 16'(v);
        @(posedge clk);
        #1;
        ib.enqueue_sig = 1'b0;
        ib.dequeue_sig = 1'b0;
        if (d && sb.size() > 0) void'(sb.pop_front());
        if (e) begin
            k = 0;
            while (k < sb.size() && !(v < sb[k].val)) k++;
            sb.insert(k, '{val: v, tag: next_tag});
            next_tag++;
        end
        chk("b_data_out", ib.data_out, (sb.size() > 0) ? sb[0].val : 0);
        chk("b_count", ib.count, sb.size());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_data_out", ia.data_out, 0);
        chk("rst_count", ia.count, 0);
        chk("rst_empty", ia.empty, 1);
        chk("rst_full", ia.full, 0);
        chk("rst_overflow", ia.overflow, 0);
        chk("rst_underflow", ia.underflow, 0);
        chk("rst_b_count", ib.count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mq.delete();
        sb.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        next_tag = 0;
    endtask

    initial begin
        ia.enqueue_sig = 1'b0; ia.dequeue_sig = 1'b0; ia.data_in = '0;
        ib.enqueue_sig = 1'b0; ib.dequeue_sig = 1'b0; ib.data_in = '0;
        #2;
        do_reset();

        // Directed ordering sequence, max-first.
        tv.push_back('{1, 0, 2,  2,  1, 0});
        tv.push_back('{1, 0, 2,  2,  2, 0});
        tv.push_back('{1, 0, 10, 10, 3, 0});
        tv.push_back('{1, 0, 8,  10, 4, 0});
        tv.push_back('{0, 1, 0,  8,  3, 0});
        tv.push_back('{1, 0, 6,  8,  4, 0});
        tv.push_back('{1, 0, 0,  8,  5, 0});
        tv.push_back('{0, 1, 0,  6,  4, 0});
        tv.push_back('{0, 1, 0,  2,  3, 0});
        tv.push_back('{0, 1, 0,  2,  2, 0});
        tv.push_back('{0, 1, 0,  0,  1, 0});
        tv.push_back('{0, 1, 0,  0,  0, 1});
        foreach (tv[k]) begin
            step_a(tv[k].enq, tv[k].deq, tv[k].din);
            chk("tv_data_out", ia.data_out, tv[k].exp_out);
            chk("tv_count", ia.count, tv[k].exp_cnt);
            chk("tv_empty", ia.empty, tv[k].exp_empty);
        end
        chk("tv_underflow", ia.underflow, 0);

        // Simultaneous enqueue+dequeue.
        do_reset();
        step_a(1, 0, 9);
        step_a(1, 0, 3);
        step_a(1, 1, 5);
        chk("swap_head", ia.data_out, 5);
        chk("swap_count", ia.count, 2);
        step_a(0, 1, 0);
        chk("swap_next", ia.data_out, 3);
        step_a(0, 1, 0);
        step_a(1, 1, 7);
        chk("swap_empty_head", ia.data_out, 7);
        chk("swap_empty_count", ia.count, 1);
        chk("swap_empty_udf", ia.underflow, 1);

        // Full queue behaviour.
        do_reset();
        for (int unsigned v = 1; v <= 8; v++) step_a(1, 0, v);
        step_a(1, 0, 9);
        chk("full_count", ia.count, 8);
`ifdef SPQ_EVICT_EN
        chk("full_head", ia.data_out, 9);
        chk("full_ovf", ia.overflow, 0);
`else
        chk("full_head", ia.data_out, 8);
        chk("full_ovf", ia.overflow, 1);
`endif
        step_a(1, 0, 0);
        chk("full_ovf_zero", ia.overflow, 1);
        for (int unsigned k = 0; k < 7; k++) step_a(0, 1, 0);
`ifdef SPQ_EVICT_EN
        chk("full_tail", ia.data_out, 2);
`else
        chk("full_tail", ia.data_out, 1);
`endif
        step_a(1, 1, 200);
        chk("full_swap_last", ia.data_out, 200);

        // Reset mid-operation.
        do_reset();
        for (int unsigned v = 0; v < 5; v++) step_a(1, 0, 10 + v);
        do_reset();
        step_a(1, 0, 4);
        chk("post_rst_head", ia.data_out, 4);
        chk("post_rst_count", ia.count, 1);

        // Randomized run: fill-biased phase, then drain-biased phase.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            bit e, d;
            if ((k / 150) % 2 == 0) begin
                e = ($urandom_range(0, 9) < 7);
                d = ($urandom_range(0, 9) < 3);
            end else begin
                e = ($urandom_range(0, 9) < 3);
                d = ($urandom_range(0, 9) < 7);
            end
            step_a(e, d, $urandom_range(0, 15));
        end

        // Min-first 16-bit, ties leave in arrival order.
        do_reset();
        step_b(1, 0, 300);
        step_b(1, 0, 7);
        step_b(1, 0, 65535);
        step_b(1, 0, 7);
        chk("b_head_min", ib.data_out, 7);
        step_b(0, 1, 0);
        chk("b_second_7", ib.data_out, 7);
        step_b(0, 1, 0);
        chk("b_300", ib.data_out, 300);
        step_b(0, 1, 0);
        chk("b_65535", ib.data_out, 65535);
        step_b(0, 1, 0);
        chk("b_empty", ib.empty, 1);
        for (int k = 0; k < 200; k++) begin
            bit e, d;
            e = ($urandom_range(0, 9) < 5);
            d = ($urandom_range(0, 9) < 4) && (sb.size() > 0);
            if (e && !d && sb.size() == 8) e = 1'b0;
            step_b(e, d, $urandom_range(0, 3) * 21845);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
